cnn16_fp16_mul_pipe: RTL and testbench

- Pipelined IEEE 754 half-precision multiplier that computes the FPMUL result for the CNN16 datapath.
- Operand A comes from FPLOAD, operand B comes from AC. The result feeds the FPMUL register's load input.
- Replaces the single-cycle simplified multiply with a correctly rounded, 3-stage, backpressure-capable unit.

---
 rtl/cnn16_fp16_mul_pipe.sv | 173 +++++++++++++++++
 tb/tb_cnn16_fp16_mul_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn16_fp16_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module : cnn16_fp16_mul_pipe
// Brief  : 3-stage IEEE 754 binary16 multiplier (RNE, DAZ/FTZ) with ready/valid
// Rev    : 1.0
// ============================================================================
module cnn16_fp16_mul_pipe #(
  parameter logic [15:0] NAN_VALUE = 16'h7E00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_a_i,
  input  logic [15:0] in_b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_result_o,
  output logic        out_overflow_o,
  output logic        out_underflow_o,
  output logic        out_invalid_o,
  output logic        busy_o
);

  logic adv;

  // S1 unpack
  logic [4:0]         ea, eb;
  logic [9:0]         fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               s1_sign_d, s1_inv_d, s1_inf_d, s1_zero_d;
  logic [21:0]        s1_prod_d;
  logic signed [6:0]  s1_exp_d;

  logic               s1_valid_q, s1_sign_q, s1_inv_q, s1_inf_q, s1_zero_q;
  logic [21:0]        s1_prod_q;
  logic signed [6:0]  s1_exp_q;

  // S2 normalize / round
  logic               hi;
  logic [9:0]         man_t;
  logic               guard, sticky, rnd, carry;
  logic [9:0]         s2_man_d;
  logic signed [6:0]  s2_exp_d;

  logic               s2_valid_q, s2_sign_q, s2_inv_q, s2_inf_q, s2_zero_q;
  logic [9:0]         s2_man_q;
  logic signed [6:0]  s2_exp_q;

  // S3 pack
  logic [15:0]        s3_result_d;
  logic               s3_ovf_d, s3_unf_d, s3_inv_d;

  logic               s3_valid_q, s3_ovf_q, s3_unf_q, s3_inv_q;
  logic [15:0]        s3_result_q;

  assign adv        = !s3_valid_q | out_ready_i;
  assign in_ready_o = adv;

  assign ea = in_a_i[14:10];
  assign eb = in_b_i[14:10];
  assign fa = in_a_i[9:0];
  assign fb = in_b_i[9:0];

  // Subnormal inputs count as zero, so a zero exponent field alone marks zero.
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'h1F) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1F) && (fb == 10'd0);
  assign a_nan  = (ea == 5'h1F) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1F) && (fb != 10'd0);

  assign s1_sign_d = in_a_i[15] ^ in_b_i[15];
  assign s1_inv_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign s1_inf_d  = a_inf | b_inf;
  assign s1_zero_d = a_zero | b_zero;
  assign s1_prod_d = {11'd0, 1'b1, fa} * {11'd0, 1'b1, fb};
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;

  assign hi     = s1_prod_q[21];
  assign man_t  = hi ? s1_prod_q[20:11] : s1_prod_q[19:10];
  assign guard  = hi ? s1_prod_q[10]    : s1_prod_q[9];
  assign sticky = hi ? (|s1_prod_q[9:0]) : (|s1_prod_q[8:0]);
  assign rnd    = guard & (sticky | man_t[0]);

  // A carry out of the mantissa wraps it to zero; the exponent absorbs the bit.
  assign {carry, s2_man_d} = {1'b0, man_t} + {10'd0, rnd};
  assign s2_exp_d = s1_exp_q + $signed({5'd0, {1'b0, hi} + {1'b0, carry}});

  always_comb begin
    s3_result_d = {s2_sign_q, s2_exp_q[4:0], s2_man_q};
    s3_ovf_d    = 1'b0;
    s3_unf_d    = 1'b0;
    s3_inv_d    = 1'b0;
    if (s2_inv_q) begin
      s3_result_d = NAN_VALUE;
      s3_inv_d    = 1'b1;
    end else if (s2_inf_q) begin
      s3_result_d = {s2_sign_q, 5'h1F, 10'd0};
    end else if (s2_zero_q) begin
      s3_result_d = {s2_sign_q, 15'd0};
    end else if (s2_exp_q >= 7'sd31) begin
      s3_result_d = {s2_sign_q, 5'h1F, 10'd0};
      s3_ovf_d    = 1'b1;
    end else if (s2_exp_q <= 7'sd0) begin
      s3_result_d = {s2_sign_q, 15'd0};
      s3_unf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_prod_q   <= 22'd0;
      s1_exp_q    <= 7'sd0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_man_q    <= 10'd0;
      s2_exp_q    <= 7'sd0;
      s3_valid_q  <= 1'b0;
      s3_ovf_q    <= 1'b0;
      s3_unf_q    <= 1'b0;
      s3_inv_q    <= 1'b0;
      s3_result_q <= 16'd0;
    end else begin
      // flush only kills valid bits; stale data behind a zero valid is harmless
      if (flush_i) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
        s3_valid_q <= 1'b0;
      end else if (adv) begin
        s1_valid_q <= in_valid_i;
        s2_valid_q <= s1_valid_q;
        s3_valid_q <= s2_valid_q;
      end
      if (adv) begin
        s1_sign_q   <= s1_sign_d;
        s1_inv_q    <= s1_inv_d;
        s1_inf_q    <= s1_inf_d;
        s1_zero_q   <= s1_zero_d;
        s1_prod_q   <= s1_prod_d;
        s1_exp_q    <= s1_exp_d;
        s2_sign_q   <= s1_sign_q;
        s2_inv_q    <= s1_inv_q;
        s2_inf_q    <= s1_inf_q;
        s2_zero_q   <= s1_zero_q;
        s2_man_q    <= s2_man_d;
        s2_exp_q    <= s2_exp_d;
        s3_ovf_q    <= s3_ovf_d;
        s3_unf_q    <= s3_unf_d;
        s3_inv_q    <= s3_inv_d;
        s3_result_q <= s3_result_d;
      end
    end
  end

  assign out_valid_o     = s3_valid_q;
  assign out_result_o    = s3_result_q;
  assign out_overflow_o  = s3_ovf_q;
  assign out_underflow_o = s3_unf_q;
  assign out_invalid_o   = s3_inv_q;
  assign busy_o          = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn16_fp16_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_cnn16_fp16_mul_pipe
// Brief  : Randomized + directed bench for the fp16 multiplier pipeline
// Rev    : 1.0
// ============================================================================
module tb_cnn16_fp16_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_overflow, out_underflow, out_invalid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [18:0] exp_q [$];
  logic [18:0] mon_exp;

  cnn16_fp16_mul_pipe #(.NAN_VALUE(16'h7E00)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_a_i          (in_a),
    .in_b_i          (in_b),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_result_o    (out_result),
    .out_overflow_o  (out_overflow),
    .out_underflow_o (out_underflow),
    .out_invalid_o   (out_invalid),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, rounded to 11
  // significant bits by remainder comparison. Returns {inv, ovf, unf, result}.
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, fa, fb, e, sh;
    longint p, q, rem, half;
    logic   s, an, bn, ai, bi, az, bz;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    az = (ea == 0);               bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 16'h7E00};
    if (ai || bi) return {3'b000, s, 15'h7C00};
    if (az || bz) return {3'b000, s, 15'h0000};
    p  = longint'(1024 + fa) * longint'(1024 + fb);
    sh = (p >= 64'd2097152) ? 11 : 10;
    e  = ea + eb - 15 + (sh - 10);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {3'b010, s, 15'h7C00};
    if (e <= 0)  return {3'b001, s, 15'h0000};
    return {3'b000, s, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] sp [9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                            16'h0001, 16'h8201, 16'h7BFF, 16'h0400};
    int unsigned sel;
    logic [15:0] r;
    sel = $urandom_range(0, 9);
    r   = 16'($urandom);
    if (sel == 0) return r;
    if (sel == 1) return sp[$urandom_range(0, 8)];
    if (sel == 2) return {r[15], 5'($urandom_range(1, 30)), r[9:0]};
    return {r[15], 5'($urandom_range(8, 22)), r[9:0]};
  endfunction

  // Scoreboard: consume on output handshake, enqueue on accepted input.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check_eq("sb_result", {out_invalid, out_overflow, out_underflow, out_result}, mon_exp);
          n_out++;
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_mul(in_a, in_b));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the pair is taken.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int g;
    g = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("send_stall", 32'(g < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single op with out_ready=1; result must appear on the third clock edge.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [18:0] exp);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    check_eq({tag, "_rdy"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_lat"}, k, 3);
    check_eq(tag, {out_invalid, out_overflow, out_underflow, out_result}, exp);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n_before;
    logic [15:0] held;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {out_valid, busy, out_overflow, out_underflow, out_invalid, out_result},
             {5'b0, 16'h0000});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);

    directed("mul_1p5sq",  16'h3E00, 16'h3E00, {3'b000, 16'h4080});
    directed("mul_2x3",    16'h4000, 16'h4200, {3'b000, 16'h4600});
    directed("mul_neg",    16'hC000, 16'h4200, {3'b000, 16'hC600});
    directed("rnd_down",   16'h3C01, 16'h3C01, {3'b000, 16'h3C02});
    directed("rnd_tie",    16'h3E00, 16'h3C03, {3'b000, 16'h3E04});
    directed("rnd_renorm", 16'h3BFF, 16'h3C01, {3'b000, 16'h3C00});
    directed("ovf",        16'h7BFF, 16'h4000, {3'b010, 16'h7C00});
    directed("unf",        16'h0400, 16'h3800, {3'b001, 16'h0000});
    directed("inv_0xinf",  16'h7C00, 16'h0000, {3'b100, 16'h7E00});
    directed("daz",        16'h0001, 16'h4000, {3'b000, 16'h0000});
    directed("neg_zero",   16'h8000, 16'h3C00, {3'b000, 16'h8000});
    directed("inf_x_2",    16'h4000, 16'hFC00, {3'b000, 16'hFC00});
    drain("drain_directed");

    // Backpressure: five back-to-back pairs, consumer stalls four cycles.
    n_before = n_out;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(16'h3C00 + 16'(i * 16'h0101), 16'h4000 + 16'(i * 16'h0013));
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        check_eq("bp_first_valid", 32'(out_valid), 1);
        out_ready = 1'b0;
        held = out_result;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("bp_in_ready", 32'(in_ready), 0);
          check_eq("bp_hold", {out_valid, out_result}, {1'b1, held});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check_eq("bp_count", n_out - n_before, 5);

    // Flush with a valid pair presented in the same cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(16'h3C00 + 16'(i), 16'h4100);
    flush = 1'b1; in_valid = 1'b1; in_a = 16'h4400; in_b = 16'h4400;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_empty", {out_valid, busy}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("flush_quiet", 32'(out_valid), 0);
    end
    directed("post_flush", 16'h3C00, 16'h4000, {3'b000, 16'h4000});
    drain("drain_flush");

    // Asynchronous reset with results in flight and out_valid held high.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h4200, 16'h4200);
    send(16'h4400, 16'h3C00);
    @(posedge clk); #1;
    check_eq("rst_pre_valid", {out_valid, busy}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {out_valid, busy, out_result}, 18'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    directed("post_rst", 16'h3E00, 16'h4000, {3'b000, 16'h4200});
    drain("drain_rst");

    // Random traffic with random stalls and occasional flushes.
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
